// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory behind a valid/ready request channel and a
// valid/ready response channel. One transaction is in flight at a time:
// a request is latched in IDLE, waits WAIT_CYCLES cycles, executes, and the
// response is held until the initiator takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, >= 4)
//   WAIT_CYCLES  access wait states (0..15)
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-high; clears FSM, response and storage
//   req_valid   request present
//   req_ready   block can accept a request (IDLE only)
//   req_addr    byte address
//   req_we      1 = write, 0 = read
//   req_be      write byte enables, bit i -> bits [8i+7:8i]
//   req_wdata   write data
//   resp_valid  response available (RESP only)
//   resp_ready  initiator accepts the response
//   resp_rdata  read data; 0 for writes and errors
//   resp_err    misaligned or out-of-range request
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam bit          ZERO_WAIT  = (WAIT_CYCLES == 0);
    // Only meaningful when WAIT_CYCLES > 0; the other branch avoids underflow.
    localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    logic [31:0] r_rdata;
    logic [31:0] w_rdata_next;
    logic        r_err;
    logic        w_err_next;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_exec;
    logic [31:0]   w_op_addr;
    logic          w_op_we;
    logic [3:0]    w_op_be;
    logic [31:0]   w_op_wdata;
    logic          w_op_err;
    logic [AW-1:0] w_idx;

    assign w_accept = req_valid && (r_state == StIdle);

    // With zero wait states the access executes on the accepting edge, so the
    // operands come straight from the request inputs rather than the latch.
    assign w_op_addr  = (r_state == StIdle) ? req_addr  : r_addr;
    assign w_op_we    = (r_state == StIdle) ? req_we    : r_we;
    assign w_op_be    = (r_state == StIdle) ? req_be    : r_be;
    assign w_op_wdata = (r_state == StIdle) ? req_wdata : r_wdata;

    assign w_op_err = (w_op_addr[1:0] != 2'b00) || ({1'b0, w_op_addr} >= ADDR_LIMIT);
    assign w_idx    = w_op_addr[AW+1:2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_exec       = 1'b0;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;

        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (ZERO_WAIT) begin
                        w_exec       = 1'b1;
                        w_state_next = StResp;
                    end else begin
                        w_cnt_next   = CNT_INIT;
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_exec       = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_next = StIdle;
                    w_rdata_next = 32'd0;
                    w_err_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_exec) begin
            w_err_next   = w_op_err;
            w_rdata_next = (!w_op_we && !w_op_err) ? r_mem[w_idx] : 32'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_be    <= req_be;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_exec && w_op_we && !w_op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_op_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = (r_state == StResp);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
